// File: rtl/alu_top.sv
// Registered 16-bit ALU: arithmetic, logic, compare and shift units.
// Unit flags are combinational; results carry one cycle of latency.
module alu_top #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic [WIDTH-1:0] Arith_OUT,
    output logic             carry_OUT,
    output logic             Arith_flag,
    output logic [WIDTH-1:0] Logic_OUT,
    output logic             Logic_flag,
    output logic             CMP_OUT,
    output logic             CMP_flag,
    output logic [WIDTH-1:0] SHIFT_OUT,
    output logic             SHIFT_flag
);

    localparam logic [1:0] OP_0 = 2'b00;
    localparam logic [1:0] OP_1 = 2'b01;
    localparam logic [1:0] OP_2 = 2'b10;
    localparam logic [1:0] OP_3 = 2'b11;

    logic [1:0]         op;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;

    logic [WIDTH-1:0] arith_d;
    logic             carry_d;
    logic [WIDTH-1:0] logic_d;
    logic             cmp_d;
    logic [WIDTH-1:0] shift_d;

    assign op   = ALU_FUN[1:0];
    assign sum  = {1'b0, A} + {1'b0, B};
    assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    assign quot = (B == '0) ? '1 : A / B;

    // An unknown unit field matches no arm, so every flag stays low.
    always_comb begin
        Arith_flag = 1'b0;
        Logic_flag = 1'b0;
        CMP_flag   = 1'b0;
        SHIFT_flag = 1'b0;
        unique case (1'b1)
            (ALU_FUN[3:2] == 2'b00): Arith_flag = 1'b1;
            (ALU_FUN[3:2] == 2'b01): Logic_flag = 1'b1;
            (ALU_FUN[3:2] == 2'b10): CMP_flag   = 1'b1;
            (ALU_FUN[3:2] == 2'b11): SHIFT_flag = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        arith_d = '0;
        carry_d = 1'b0;
        if (Arith_flag) begin
            case (op)
                OP_0: {carry_d, arith_d} = sum;
                OP_1: begin
                    arith_d = A - B;
                    carry_d = (A < B);
                end
                OP_2: begin
                    arith_d = prod[WIDTH-1:0];
                    carry_d = |prod[2*WIDTH-1:WIDTH];
                end
                OP_3: arith_d = quot;
                default: ;
            endcase
        end
    end

    always_comb begin
        logic_d = '0;
        if (Logic_flag) begin
            case (op)
                OP_0: logic_d = A & B;
                OP_1: logic_d = A | B;
                OP_2: logic_d = ~(A & B);
                OP_3: logic_d = ~(A | B);
                default: ;
            endcase
        end
    end

    always_comb begin
        cmp_d = 1'b0;
        if (CMP_flag) begin
            case (op)
                OP_0: cmp_d = 1'b0;
                OP_1: cmp_d = (A == B);
                OP_2: cmp_d = (A > B);
                OP_3: cmp_d = (A < B);
                default: ;
            endcase
        end
    end

    always_comb begin
        shift_d = '0;
        if (SHIFT_flag) begin
            case (op)
                OP_0: shift_d = {1'b0, A[WIDTH-1:1]};
                OP_1: shift_d = {A[WIDTH-2:0], 1'b0};
                OP_2: shift_d = {1'b0, B[WIDTH-1:1]};
                OP_3: shift_d = {B[WIDTH-2:0], 1'b0};
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Arith_OUT <= '0;
            carry_OUT <= 1'b0;
            Logic_OUT <= '0;
            CMP_OUT   <= 1'b0;
            SHIFT_OUT <= '0;
        end else begin
            Arith_OUT <= arith_d;
            carry_OUT <= carry_d;
            Logic_OUT <= logic_d;
            CMP_OUT   <= cmp_d;
            SHIFT_OUT <= shift_d;
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: vector table through a scoreboard
// queue, plus hand-written reset sequences.
module tb_alu_top;

    logic        CLK;
    logic        RST;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  ALU_FUN;
    logic [15:0] Arith_OUT;
    logic        carry_OUT;
    logic        Arith_flag;
    logic [15:0] Logic_OUT;
    logic        Logic_flag;
    logic        CMP_OUT;
    logic        CMP_flag;
    logic [15:0] SHIFT_OUT;
    logic        SHIFT_flag;

    alu_top #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .Arith_OUT (Arith_OUT),
        .carry_OUT (carry_OUT),
        .Arith_flag(Arith_flag),
        .Logic_OUT (Logic_OUT),
        .Logic_flag(Logic_flag),
        .CMP_OUT   (CMP_OUT),
        .CMP_flag  (CMP_flag),
        .SHIFT_OUT (SHIFT_OUT),
        .SHIFT_flag(SHIFT_flag)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
        logic [15:0] arith;
        logic        carry;
        logic [15:0] lgc;
        logic        cmp;
        logic [15:0] shift;
    } vec_t;

    vec_t vecs[23];
    vec_t sb[$];
    int   n_pass;
    int   n_total;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_flags(input string name, input logic [3:0] fun);
        logic [3:0] exp;
        exp = 4'b0001 << fun[3:2];
        chk(name, {28'd0, SHIFT_flag, CMP_flag, Logic_flag, Arith_flag},
            {28'd0, exp});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " arith"}, {16'd0, Arith_OUT}, 32'd0);
        chk({tag, " carry"}, {31'd0, carry_OUT}, 32'd0);
        chk({tag, " logic"}, {16'd0, Logic_OUT}, 32'd0);
        chk({tag, " cmp"},   {31'd0, CMP_OUT},   32'd0);
        chk({tag, " shift"}, {16'd0, SHIFT_OUT}, 32'd0);
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] fun,
                                input logic [15:0] ar, input logic c,
                                input logic [15:0] lg, input logic cm,
                                input logic [15:0] sh);
        vec_t v;
        v.a = a; v.b = b; v.fun = fun;
        v.arith = ar; v.carry = c; v.lgc = lg; v.cmp = cm; v.shift = sh;
        return v;
    endfunction

    initial begin
        vec_t e;
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = mk(16'd10, 16'd5, 4'b0000, 16'd15, 0, 0, 0, 0);
        vecs[1]  = mk(16'd10, 16'd5, 4'b0001, 16'd5, 0, 0, 0, 0);
        vecs[2]  = mk(16'd10, 16'd5, 4'b0010, 16'd50, 0, 0, 0, 0);
        vecs[3]  = mk(16'd10, 16'd5, 4'b0011, 16'd2, 0, 0, 0, 0);
        vecs[4]  = mk(16'hFFFF, 16'd1, 4'b0000, 16'd0, 1, 0, 0, 0);
        vecs[5]  = mk(16'd3, 16'd5, 4'b0001, 16'hFFFE, 1, 0, 0, 0);
        vecs[6]  = mk(16'd10, 16'd0, 4'b0011, 16'hFFFF, 0, 0, 0, 0);
        vecs[7]  = mk(16'h0100, 16'h0100, 4'b0010, 16'd0, 1, 0, 0, 0);
        vecs[8]  = mk(16'd10, 16'd5, 4'b0100, 0, 0, 16'h0000, 0, 0);
        vecs[9]  = mk(16'd10, 16'd5, 4'b0101, 0, 0, 16'h000F, 0, 0);
        vecs[10] = mk(16'd10, 16'd5, 4'b0110, 0, 0, 16'hFFFF, 0, 0);
        vecs[11] = mk(16'd10, 16'd5, 4'b0111, 0, 0, 16'hFFF0, 0, 0);
        vecs[12] = mk(16'd10, 16'd5, 4'b1000, 0, 0, 0, 0, 0);
        vecs[13] = mk(16'd10, 16'd5, 4'b1001, 0, 0, 0, 0, 0);
        vecs[14] = mk(16'd10, 16'd5, 4'b1010, 0, 0, 0, 1, 0);
        vecs[15] = mk(16'd10, 16'd5, 4'b1011, 0, 0, 0, 0, 0);
        vecs[16] = mk(16'd7, 16'd7, 4'b1001, 0, 0, 0, 1, 0);
        vecs[17] = mk(16'd3, 16'd5, 4'b1011, 0, 0, 0, 1, 0);
        vecs[18] = mk(16'd10, 16'd5, 4'b1100, 0, 0, 0, 0, 16'd5);
        vecs[19] = mk(16'd10, 16'd5, 4'b1101, 0, 0, 0, 0, 16'd20);
        vecs[20] = mk(16'd10, 16'd5, 4'b1110, 0, 0, 0, 0, 16'd2);
        vecs[21] = mk(16'd10, 16'd5, 4'b1111, 0, 0, 0, 0, 16'd10);
        vecs[22] = mk(16'h8001, 16'd0, 4'b1101, 0, 0, 0, 0, 16'h0002);

        // Reset with no clock edge yet.
        RST     = 1'b0;
        A       = 16'd10;
        B       = 16'd5;
        ALU_FUN = 4'b0000;
        #2;
        chk_zero("reset");

        // Released reset holds zero until the first edge.
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk_zero("release");

        for (int i = 0; i < 23; i++) begin
            @(negedge CLK);
            A       = vecs[i].a;
            B       = vecs[i].b;
            ALU_FUN = vecs[i].fun;
            #1;
            chk_flags($sformatf("v%0d flags", i), vecs[i].fun);
            sb.push_back(vecs[i]);
            @(posedge CLK);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d arith", i), {16'd0, Arith_OUT},
                    {16'd0, e.arith});
                chk($sformatf("v%0d carry", i), {31'd0, carry_OUT},
                    {31'd0, e.carry});
                chk($sformatf("v%0d logic", i), {16'd0, Logic_OUT},
                    {16'd0, e.lgc});
                chk($sformatf("v%0d cmp", i), {31'd0, CMP_OUT},
                    {31'd0, e.cmp});
                chk($sformatf("v%0d shift", i), {16'd0, SHIFT_OUT},
                    {16'd0, e.shift});
            end
        end

        // Asynchronous reset in the middle of a shift sequence.
        @(negedge CLK);
        A       = 16'd10;
        B       = 16'd5;
        ALU_FUN = 4'b1111;
        @(posedge CLK);
        #1;
        chk("pre-reset shift", {16'd0, SHIFT_OUT}, 32'd10);
        #2;
        RST = 1'b0;
        #1;
        chk_zero("async reset");
        @(posedge CLK);
        #1;
        chk_zero("held reset");

        @(negedge CLK);
        ALU_FUN = 4'b1101;
        RST     = 1'b1;
        #1;
        chk("post-release shift", {16'd0, SHIFT_OUT}, 32'd0);
        chk_flags("post-release flags", 4'b1101);
        @(posedge CLK);
        #1;
        chk("first edge shift", {16'd0, SHIFT_OUT}, 32'd20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- 16-bit registered ALU built from four sub-units: arithmetic, logic, compare and shift.
- A 2-bit unit decode (ALU_FUN[3:2]) enables exactly one unit. A 2-bit op field (ALU_FUN[1:0]) selects that unit's operation.
- Every result is registered on CLK, giving one-cycle latency.
- Sits in the datapath of the configurable multi-clock system. Flags tell downstream logic which result bus is currently valid.

Parameters:
- WIDTH, 16, operand and result width for A, B, Arith_OUT, Logic_OUT and SHIFT_OUT.

Ports:
- CLK  in  1  system clock; all result registers update on its rising edge.
- RST  in  1  asynchronous reset, active-low.
- A  in  16  operand A, unsigned.
- B  in  16  operand B, unsigned.
- ALU_FUN  in  4  [3:2] selects the unit, [1:0] selects the operation.
- Arith_OUT  out  16  registered arithmetic result.
- carry_OUT  out  1  registered carry/borrow of the arithmetic unit.
- Arith_flag  out  1  arithmetic unit selected.
- Logic_OUT  out  16  registered logic result.
- Logic_flag  out  1  logic unit selected.
- CMP_OUT  out  1  registered compare result.
- CMP_flag  out  1  compare unit selected.
- SHIFT_OUT  out  16  registered shift result.
- SHIFT_flag  out  1  shift unit selected.

Behaviour:
- Reset: while RST=0, all result outputs (Arith_OUT, carry_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT) are 0. Reset is asynchronous, so assertion mid-operation clears them immediately regardless of CLK.
- Unit decode is combinational; exactly one flag is high for any known ALU_FUN:
  - 00: Arith_flag
  - 01: Logic_flag
  - 10: CMP_flag
  - 11: SHIFT_flag
- Flags are not registered. They change with ALU_FUN in the same cycle, i.e. one cycle ahead of the matching result.
- Enabled unit: on each rising CLK it registers its result from the current A, B and ALU_FUN[1:0].
- Disabled units: each non-selected unit registers 0 on that same edge, so a result bus holds 0 whenever its unit is not selected.
- Latency: one CLK edge from input change to valid output. Results follow inputs every cycle while the unit stays enabled.
- Arithmetic unit (ALU_FUN[1:0]):
  - 00 ADD: {carry_OUT, Arith_OUT} = A+B, 17-bit result.
  - 01 SUB: Arith_OUT = A−B mod 2^16; carry_OUT = 1 when A<B (borrow).
  - 10 MUL: Arith_OUT = low 16 bits of A×B; carry_OUT = 1 if the high 16 bits are nonzero.
  - 11 DIV: Arith_OUT = A/B, integer quotient; B=0 gives Arith_OUT=0xFFFF; carry_OUT=0.
- Logic unit:
  - 00 A&B
  - 01 A|B
  - 10 ~(A&B)
  - 11 ~(A|B)
- Compare unit:
  - 00 CMP_OUT = 0 (NOP)
  - 01 CMP_OUT = (A==B)
  - 10 CMP_OUT = (A>B)
  - 11 CMP_OUT = (A<B)
- Shift unit (logical shifts, zero fill):
  - 00 A>>1
  - 01 A<<1
  - 10 B>>1
  - 11 B<<1
- Unknown ALU_FUN (X/Z): no flag is asserted and all result registers load 0.
- Reset release: outputs stay 0 until the first rising CLK after RST=1.
- Simultaneous ALU_FUN change and CLK edge: the value sampled at the edge is used.

Test Plan:
- Reset: A=10, B=5, RST=0 → all results 0 immediately, with no clock edge needed.
- Arithmetic, A=10, B=5, RST=1:
  - ALU_FUN=0000 → Arith_OUT=15 after one edge, Arith_flag=1, other flags 0.
  - 0001 → 5, carry 0.
  - 0010 → 50.
  - 0011 → 2.
- Carry and edge cases:
  - A=0xFFFF, B=1, ALU_FUN=0000 → Arith_OUT=0, carry_OUT=1.
  - A=3, B=5, ALU_FUN=0001 → Arith_OUT=0xFFFE, carry_OUT=1.
  - B=0, ALU_FUN=0011 → Arith_OUT=0xFFFF.
- Logic, A=10, B=5:
  - 0100 → 0x0000
  - 0101 → 0x000F
  - 0110 → 0xFFFF
  - 0111 → 0xFFF0
  - In all four cases Arith_OUT=0 after the edge.
- Compare, A=10, B=5:
  - 1000 → 0
  - 1001 → 0
  - 1010 → 1
  - 1011 → 0
  - With A=B=7: 1001 → 1.
- Shift, A=10, B=5:
  - 1100 → 5
  - 1101 → 20
  - 1110 → 2
  - 1111 → 10
  - Then assert RST mid-sequence → SHIFT_OUT=0 asynchronously.
